// File: rtl/word_unpacker_pkg.sv
// Shared types and width helpers for the word_unpacker streaming width converter.
package word_unpacker_pkg;

  localparam bit LANE_ORDER_LSB = 1'b0;
  localparam bit LANE_ORDER_MSB = 1'b1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_e;

  function automatic int lane_count(input int in_w, input int out_w);
    return in_w / out_w;
  endfunction

  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/word_unpacker_lane_select.sv
// Combinational lane multiplexer: picks lane idx_i out of a packed wide word.
module word_unpacker_lane_select
  import word_unpacker_pkg::*;
#(
  parameter int IN_W  = 128,
  parameter int OUT_W = 8,
  localparam int N    = lane_count(IN_W, OUT_W),
  localparam int IW   = idx_width(N)
) (
  input  logic [IN_W-1:0]  data_i,
  input  logic [IW-1:0]    idx_i,
  output logic [OUT_W-1:0] lane_o
);

  always_comb begin
    lane_o = '0;
    for (int i = 0; i < N; i++) begin
      if (idx_i == IW'(i)) begin
        lane_o = data_i[i*OUT_W +: OUT_W];
      end
    end
  end

endmodule

// File: rtl/word_unpacker.sv
// Accepts one wide word per handshake and streams its first K lanes out one per cycle.
module word_unpacker
  import word_unpacker_pkg::*;
#(
  parameter int IN_W      = 128,
  parameter int OUT_W     = 8,
  parameter bit MSB_FIRST = 1'b0,
  localparam int N        = lane_count(IN_W, OUT_W),
  localparam int IW       = idx_width(N),
  localparam int CW       = cnt_width(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [CW-1:0]    in_count,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [IW-1:0]    out_idx,
  output logic             out_last
);

  localparam logic [IW-1:0] TOP_IDX = IW'(N - 1);

  state_e          state_q, state_d;
  logic [IN_W-1:0] hold_q, hold_d;
  logic [IW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   last_q, last_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            last_flag_q, last_flag_d;
  logic [CW-1:0]   k_eff_s;
  logic            xfer_s;
  logic            accept_s;

  assign out_valid = (state_q == ST_EMIT);
  assign out_idx   = idx_q;
  assign out_last  = last_flag_q;
  assign xfer_s    = out_valid && out_ready;
  // Ready again in the same cycle the final lane leaves, so words stream without a bubble.
  assign in_ready  = (state_q == ST_IDLE) || (xfer_s && last_flag_q);
  assign accept_s  = in_valid && in_ready;

  always_comb begin
    if ((in_count == '0) || (in_count > CW'(N))) begin
      k_eff_s = CW'(N);
    end else begin
      k_eff_s = in_count;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    if (accept_s) begin
      state_d = ST_EMIT;
      hold_d  = in_data;
      cnt_d   = '0;
      last_d  = IW'(k_eff_s - CW'(1));
    end else if (xfer_s) begin
      if (last_flag_q) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + IW'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end

    // Index and last flag are precomputed so both leave the block straight from flops.
    if (state_d == ST_EMIT) begin
      idx_d       = (MSB_FIRST == LANE_ORDER_MSB) ? (TOP_IDX - cnt_d) : cnt_d;
      last_flag_d = (cnt_d == last_d);
    end else begin
      idx_d       = '0;
      last_flag_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      hold_q      <= '0;
      cnt_q       <= '0;
      last_q      <= '0;
      idx_q       <= '0;
      last_flag_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      idx_q       <= idx_d;
      last_flag_q <= last_flag_d;
    end
  end

  word_unpacker_lane_select #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_lane_select (
    .data_i (hold_q),
    .idx_i  (idx_q),
    .lane_o (out_data)
  );

endmodule

// File: tb/tb_word_unpacker.sv
// Self-checking bench: lane order 0 and 1 instances, scoreboard of expected lanes per instance.
module tb_word_unpacker;

  typedef struct {
    logic [7:0] data;
    logic [3:0] idx;
    logic       last;
  } lane_t;

  typedef struct {
    logic [127:0] data;
    logic [4:0]   count;
    int           sel;
    int           lanes;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [1:0]   in_valid_v  = 2'b00;
  logic [1:0]   out_ready_v = 2'b11;
  logic [127:0] in_data     = '0;
  logic [4:0]   in_count    = '0;
  wire  [1:0]   in_ready_v, out_valid_v, out_last_v;
  wire  [1:0][7:0] out_data_v;
  wire  [1:0][3:0] out_idx_v;

  int    checks = 0;
  int    errors = 0;
  int    xfer_cnt [2] = '{0, 0};
  logic  stall_prev [2] = '{1'b0, 1'b0};
  lane_t stall_val [2];
  lane_t exp_q0 [$];
  lane_t exp_q1 [$];

  localparam logic [127:0] RAMP = 128'h0F0E0D0C0B0A09080706050403020100;

  word_unpacker #(.IN_W(128), .OUT_W(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
    .in_data(in_data), .in_count(in_count),
    .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
    .out_data(out_data_v[0]), .out_idx(out_idx_v[0]), .out_last(out_last_v[0])
  );

  word_unpacker #(.IN_W(128), .OUT_W(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
    .in_data(in_data), .in_count(in_count),
    .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
    .out_data(out_data_v[1]), .out_idx(out_idx_v[1]), .out_last(out_last_v[1])
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int qsize(input int sel);
    return (sel == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  // Expected lane sequence for one accepted word on instance sel.
  task automatic push_word(input int sel, input logic [127:0] data, input logic [4:0] count);
    int    k;
    int    idx;
    lane_t l;
    k = (count == 5'd0 || count > 5'd16) ? 16 : int'(count);
    for (int j = 0; j < k; j++) begin
      idx    = (sel == 1) ? 15 - j : j;
      l.data = data[idx*8 +: 8];
      l.idx  = 4'(idx);
      l.last = (j == k - 1);
      if (sel == 0) exp_q0.push_back(l);
      else          exp_q1.push_back(l);
    end
  endtask

  // Called and returns just after a rising edge.
  task automatic send_word(input int sel, input logic [127:0] data, input logic [4:0] count);
    logic ok;
    ok = 1'b0;
    in_data = data;
    in_count = count;
    in_valid_v[sel] = 1'b1;
    for (int w = 0; w < 100 && !ok; w++) begin
      @(negedge clk);
      ok = in_ready_v[sel];
      if (!ok) begin
        @(posedge clk);
        #1;
      end
    end
    check("accept_handshake", ok, 1'b1);
    if (ok) push_word(sel, data, count);
    @(posedge clk);
    #1;
    in_valid_v[sel] = 1'b0;
  endtask

  task automatic drain(input int sel);
    for (int w = 0; w < 200 && qsize(sel) != 0; w++) @(negedge clk);
    @(negedge clk);
    check("drain_queue_empty", qsize(sel), 0);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: compares every transferred lane and checks stalls hold outputs.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      lane_t got;
      lane_t e;
      got.data = out_data_v[i];
      got.idx  = out_idx_v[i];
      got.last = out_last_v[i];
      if (rst) begin
        stall_prev[i] = 1'b0;
      end else begin
        if (stall_prev[i]) begin
          check("stall_valid_held", out_valid_v[i], 1'b1);
          check("stall_lane_held", {got.data, got.idx, got.last},
                {stall_val[i].data, stall_val[i].idx, stall_val[i].last});
        end
        if (out_valid_v[i] && out_ready_v[i]) begin
          xfer_cnt[i]++;
          check("lane_expected", qsize(i) != 0, 1'b1);
          if (qsize(i) != 0) begin
            e = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            check("lane_data", got.data, e.data);
            check("lane_idx", got.idx, e.idx);
            check("lane_last", got.last, e.last);
          end
        end
        stall_prev[i] = out_valid_v[i] && !out_ready_v[i];
        stall_val[i]  = got;
      end
    end
  end

  initial begin
    vec_t vecs [8];
    int   base;
    int   pat [6] = '{1, 0, 0, 1, 1, 1};
    logic [127:0] w1, w2;

    vecs[0] = '{RAMP, 5'd0, 0, 16};
    vecs[1] = '{RAMP, 5'd0, 1, 16};
    vecs[2] = '{{$urandom, $urandom, $urandom, $urandom}, 5'd1, 0, 1};
    vecs[3] = '{{$urandom, $urandom, $urandom, $urandom}, 5'd20, 0, 16};
    vecs[4] = '{{$urandom, $urandom, $urandom, $urandom}, 5'd5, 1, 5};
    vecs[5] = '{{$urandom, $urandom, $urandom, $urandom}, 5'd17, 1, 16};
    vecs[6] = '{{$urandom, $urandom, $urandom, $urandom}, 5'd15, 0, 15};
    vecs[7] = '{{$urandom, $urandom, $urandom, $urandom}, 5'd1, 1, 1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready_v[0], 1'b1);
    check("rst_out_valid", out_valid_v[0], 1'b0);
    check("rst_out_data", out_data_v[0], 8'h00);
    check("rst_out_idx", out_idx_v[0], 4'h0);
    check("rst_out_last", out_last_v[0], 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int v = 0; v < 8; v++) begin
      base = xfer_cnt[vecs[v].sel];
      send_word(vecs[v].sel, vecs[v].data, vecs[v].count);
      @(negedge clk);
      check("first_lane_latency", out_valid_v[vecs[v].sel], 1'b1);
      @(posedge clk);
      #1;
      drain(vecs[v].sel);
      check("lanes_per_word", xfer_cnt[vecs[v].sel] - base, vecs[v].lanes);
    end

    // Back-to-back words K=4 then K=16 with continuous valid: 20 lanes, no bubble.
    w1 = {$urandom, $urandom, $urandom, $urandom};
    w2 = {$urandom, $urandom, $urandom, $urandom};
    base = xfer_cnt[0];
    in_data = w1;
    in_count = 5'd4;
    in_valid_v[0] = 1'b1;
    @(negedge clk);
    check("b2b_idle_ready", in_ready_v[0], 1'b1);
    push_word(0, w1, 5'd4);
    @(posedge clk);
    #1;
    in_data = w2;
    in_count = 5'd16;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      check("b2b_out_valid", out_valid_v[0], 1'b1);
      check("b2b_in_ready", in_ready_v[0], (cyc == 3 || cyc == 19));
      if (cyc == 3) push_word(0, w2, 5'd16);
      @(posedge clk);
      #1;
      if (cyc == 3) in_valid_v[0] = 1'b0;
    end
    @(negedge clk);
    check("b2b_idle_after", out_valid_v[0], 1'b0);
    check("b2b_lane_total", xfer_cnt[0] - base, 20);
    @(posedge clk);
    #1;

    // Back-pressure 1,0,0,1 on a K=3 word.
    base = xfer_cnt[0];
    send_word(0, {$urandom, $urandom, $urandom, $urandom}, 5'd3);
    for (int j = 0; j < 6; j++) begin
      out_ready_v[0] = pat[j][0];
      @(negedge clk);
      @(posedge clk);
      #1;
    end
    out_ready_v[0] = 1'b1;
    check("bp_transfers", xfer_cnt[0] - base, 3);
    check("bp_queue_empty", qsize(0), 0);

    // Asynchronous reset mid-word, then a fresh word starts at lane 0.
    base = xfer_cnt[0];
    send_word(0, RAMP, 5'd16);
    for (int w = 0; w < 100 && (xfer_cnt[0] - base) < 5; w++) @(negedge clk);
    check("pre_reset_lanes", xfer_cnt[0] - base, 5);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_out_valid", out_valid_v[0], 1'b0);
    check("async_rst_in_ready", in_ready_v[0], 1'b1);
    check("async_rst_out_last", out_last_v[0], 1'b0);
    exp_q0.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    base = xfer_cnt[0];
    send_word(0, {$urandom, $urandom, $urandom, $urandom}, 5'd4);
    drain(0);
    check("post_reset_lanes", xfer_cnt[0] - base, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
